// File: rtl/timer_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_bus_arbiter
// Purpose  : Round-robin arbiter/sequencer giving two masters req/ack access
//            to the timer register bus, with per-master read-data return.
// Revision : 1.0 - initial release
// ============================================================================
module timer_bus_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              acc_en_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              gnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] c_LAST_WAIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_wait_cnt;
  logic              r_wr;
  logic              r_gnt;
  logic              r_last;
  logic              r_acc_en;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_any_req;
  logic              w_win;
  logic              w_win_wr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_last_wait;
  logic              w_latch;
  logic              w_capture;
  logic              w_done_nxt;
  logic              w_acc_en_nxt;
  logic              w_wr_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_busy_nxt;

  // On a tie the master that was not served last wins.
  assign w_any_req   = m0_req_i | m1_req_i;
  assign w_win       = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;
  assign w_win_wr    = w_win ? m1_wr_i    : m0_wr_i;
  assign w_win_addr  = w_win ? m1_addr_i  : m0_addr_i;
  assign w_win_wdata = w_win ? m1_wdata_i : m0_wdata_i;
  assign w_last_wait = (r_wait_cnt == c_LAST_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the values every registered output takes next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_done_nxt   = 1'b0;
    w_acc_en_nxt = 1'b0;
    w_wr_en_nxt  = 1'b0;
    w_addr_nxt   = '0;
    w_wdata_nxt  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = S_ACCESS;
          w_latch      = 1'b1;
          w_acc_en_nxt = 1'b1;
          w_wr_en_nxt  = w_win_wr;
          w_addr_nxt   = w_win_addr;
          w_wdata_nxt  = w_win_wdata;
        end
      end
      S_ACCESS: begin
        if (r_wr) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (RD_LAT == 0) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_last_wait) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_capture   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= 2'd0;
      r_wr       <= 1'b0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_acc_en   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_acc_en   <= w_acc_en_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_busy     <= w_busy_nxt;
      r_m0_ack   <= w_done_nxt & ~r_gnt;
      r_m1_ack   <= w_done_nxt & r_gnt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
      if (w_latch) begin
        r_gnt <= w_win;
        r_wr  <= w_win_wr;
      end else if (!w_busy_nxt) begin
        r_gnt <= 1'b0;
      end
      if (w_capture && !r_gnt) begin
        r_m0_rdata <= rdata_i;
      end
      if (w_capture && r_gnt) begin
        r_m1_rdata <= rdata_i;
      end
      if (r_state == S_DONE) begin
        r_last <= r_gnt;
      end
    end
  end

  assign acc_en_o   = r_acc_en;
  assign wr_en_o    = r_wr_en;
  assign addr_o     = r_addr;
  assign wdata_o    = r_wdata;
  assign busy_o     = r_busy;
  assign gnt_o      = r_gnt;
  assign m0_ack_o   = r_m0_ack;
  assign m1_ack_o   = r_m1_ack;
  assign m0_rdata_o = r_m0_rdata;
  assign m1_rdata_o = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_bus_arbiter
// Purpose  : Directed self-checking bench; three arbiters with RD_LAT 0/1/3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0;
  logic        m0_wr = 1'b0;
  logic [2:0]  m0_addr = 3'd0;
  logic [15:0] m0_wdata = 16'd0;
  logic        m1_req [3];
  logic        m1_wr = 1'b0;
  logic [2:0]  m1_addr = 3'd0;
  logic [15:0] m1_wdata = 16'd0;

  logic        acc_en [3];
  logic        wr_en [3];
  logic [2:0]  addr_o [3];
  logic [15:0] wdata_o [3];
  logic [15:0] rdata [3];
  logic        ack0 [3];
  logic        ack1 [3];
  logic [15:0] rdata0 [3];
  logic [15:0] rdata1 [3];
  logic        busy [3];
  logic        gnt [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_model(input logic [2:0] a);
    return (a == 3'd5) ? 16'h00AB : (16'h5A00 | {13'd0, a});
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [2:0] hold;
    int         age;

    // Register block: data is only valid exactly LAT cycles after acc_en.
    always_ff @(posedge clk) begin
      if (rst) begin
        age <= 0;
      end else if (acc_en[g]) begin
        hold <= addr_o[g];
        age  <= 1;
      end else if (age != 0 && age < 7) begin
        age <= age + 1;
      end
    end

    assign rdata[g] = acc_en[g] ? ((LAT == 0) ? rd_model(addr_o[g]) : 16'hDEAD)
                                : ((LAT != 0 && age == LAT) ? rd_model(hold) : 16'hDEAD);

    timer_bus_arbiter #(.ADDR_W(3), .DATA_W(16), .RD_LAT(LAT)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .m0_req_i   (m0_req),
      .m0_wr_i    (m0_wr),
      .m0_addr_i  (m0_addr),
      .m0_wdata_i (m0_wdata),
      .m0_ack_o   (ack0[g]),
      .m0_rdata_o (rdata0[g]),
      .m1_req_i   (m1_req[g]),
      .m1_wr_i    (m1_wr),
      .m1_addr_i  (m1_addr),
      .m1_wdata_i (m1_wdata),
      .m1_ack_o   (ack1[g]),
      .m1_rdata_o (rdata1[g]),
      .acc_en_o   (acc_en[g]),
      .wr_en_o    (wr_en[g]),
      .addr_o     (addr_o[g]),
      .wdata_o    (wdata_o[g]),
      .rdata_i    (rdata[g]),
      .busy_o     (busy[g]),
      .gnt_o      (gnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_at [3];
    logic [15:0] rd_at [3];
    int waited;
    int n_ack;
    int n_acc;

    for (int g = 0; g < 3; g++) begin
      m1_req[g] = 1'b0;
      ack_at[g] = 0;
      rd_at[g]  = 16'h0;
    end

    // Reset state
    step();
    chk("reset_bus", {11'd0, acc_en[1], wr_en[1], addr_o[1], wdata_o[1]}, 32'd0);
    chk("reset_status", {28'd0, busy[1], gnt[1], ack0[1], ack1[1]}, 32'd0);
    chk("reset_rdata", {rdata0[1], rdata1[1]}, 32'd0);
    rst = 1'b0;
    step();

    // Read latency on all three instances: m1 reads addr 5
    m1_wr   = 1'b0;
    m1_addr = 3'd5;
    for (int g = 0; g < 3; g++) m1_req[g] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        if (m1_req[g] && ack1[g]) begin
          ack_at[g] = k;
          rd_at[g]  = rdata1[g];
          m1_req[g] = 1'b0;
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rdlat%0d_ack_cycle", lat_of(g)), ack_at[g], 32'(2 + lat_of(g)));
      chk($sformatf("rdlat%0d_m1_rdata", lat_of(g)), {16'd0, rd_at[g]}, 32'h00AB);
      chk($sformatf("rdlat%0d_m0_rdata", lat_of(g)), {16'd0, rdata0[g]}, 32'd0);
    end

    // Single write from m0 on RD_LAT=1 instance
    m0_wr = 1'b1; m0_addr = 3'd3; m0_wdata = 16'h1234; m0_req = 1'b1;
    step();
    chk("wr_bus", {11'd0, acc_en[1], wr_en[1], addr_o[1], wdata_o[1]},
        {11'd0, 1'b1, 1'b1, 3'd3, 16'h1234});
    chk("wr_status", {29'd0, busy[1], gnt[1], ack0[1]}, {29'd0, 3'b100});
    step();
    chk("wr_bus_off", {11'd0, acc_en[1], wr_en[1], addr_o[1], wdata_o[1]}, 32'd0);
    chk("wr_ack", {30'd0, ack0[1], ack1[1]}, 32'd2);
    m0_req = 1'b0;
    step();
    chk("wr_after", {29'd0, ack0[1], busy[1], acc_en[1]}, 32'd0);
    chk("wr_rdata_keep", {rdata0[1], rdata1[1]}, {16'd0, 16'h00AB});

    // Tie after reset, then strict alternation with both held
    do_reset();
    m0_wr = 1'b1; m0_addr = 3'd1; m0_wdata = 16'h1111; m0_req = 1'b1;
    m1_wr = 1'b1; m1_addr = 3'd2; m1_wdata = 16'h2222; m1_req[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waited = 0;
      do begin
        step();
        waited++;
      end while (!acc_en[1] && waited < 10);
      chk($sformatf("tie%0d_acc", i), {31'd0, acc_en[1]}, 32'd1);
      chk($sformatf("tie%0d_gnt", i), {31'd0, gnt[1]}, 32'(i % 2));
      chk($sformatf("tie%0d_addr", i), {29'd0, addr_o[1]}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i > 0) chk($sformatf("tie%0d_gap", i), waited, 32'd3);
    end
    m0_req = 1'b0;
    m1_req[1] = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Starvation: m1 reads continuously, m0 raises one write during m1 WAIT
    do_reset();
    m1_wr = 1'b0; m1_addr = 3'd5; m1_req[1] = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc_en[1] && waited < 10);
    chk("starve_first_gnt", {30'd0, acc_en[1], gnt[1]}, 32'd3);
    step();
    m0_wr = 1'b1; m0_addr = 3'd6; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc_en[1] && waited < 12);
    chk("starve_m0_delay", waited, 32'd3);
    chk("starve_m0_bus", {11'd0, acc_en[1], gnt[1], addr_o[1], wdata_o[1]},
        {11'd0, 1'b1, 1'b0, 3'd6, 16'hBEEF});
    step();
    chk("starve_m0_ack", {30'd0, ack0[1], ack1[1]}, 32'd2);
    m0_req = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc_en[1] && waited < 10);
    chk("starve_m1_next", {30'd0, acc_en[1], gnt[1]}, 32'd3);
    m1_req[1] = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!ack1[1] && waited < 10);
    chk("starve_m1_rdata", {15'd0, ack1[1], rdata1[1]}, {15'd0, 1'b1, 16'h00AB});
    step();
    step();

    // Reset asserted during WAIT of an m0 read
    m0_wr = 1'b0; m0_addr = 3'd4; m0_req = 1'b1;
    step();
    chk("rstmid_acc", {27'd0, acc_en[1], wr_en[1], addr_o[1]}, {27'd0, 2'b10, 3'd4});
    step();
    chk("rstmid_wait", {29'd0, busy[1], acc_en[1], ack0[1]}, 32'd4);
    #3;
    rst = 1'b1;
    m0_req = 1'b0;
    #1;
    chk("rstmid_bus", {11'd0, acc_en[1], wr_en[1], addr_o[1], wdata_o[1]}, 32'd0);
    chk("rstmid_status", {28'd0, busy[1], gnt[1], ack0[1], ack1[1]}, 32'd0);
    chk("rstmid_rdata", {rdata0[1], rdata1[1]}, 32'd0);
    step();
    step();
    chk("rstmid_no_ack", {30'd0, ack0[1], ack1[1]}, 32'd0);
    rst = 1'b0;
    step();
    m0_req = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!ack0[1] && waited < 10);
    m0_req = 1'b0;
    chk("rstmid_fresh_lat", waited, 32'd3);
    chk("rstmid_fresh_rdata", {16'd0, rdata0[1]}, 32'h5A04);
    step();
    step();

    // Early drop: m0 releases req during ACCESS of its write
    m0_wr = 1'b1; m0_addr = 3'd7; m0_wdata = 16'h0F0F; m0_req = 1'b1;
    step();
    chk("drop_bus", {11'd0, acc_en[1], wr_en[1], addr_o[1], wdata_o[1]},
        {11'd0, 1'b1, 1'b1, 3'd7, 16'h0F0F});
    m0_req = 1'b0;
    step();
    chk("drop_ack", {31'd0, ack0[1]}, 32'd1);
    n_ack = 0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack0[1]) n_ack++;
      if (acc_en[1]) n_acc++;
    end
    chk("drop_no_repeat", {n_ack[15:0], n_acc[15:0]}, 32'd0);
    chk("drop_rdata_keep", {16'd0, rdata0[1]}, 32'h5A04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_bus_arbiter.md
# timer_bus_arbiter

Two-master arbiter and sequencer for the timer register bus (acc_en / wr_en / addr / wdata / rdata). It lets a host interface and a local controller share the timer's register block without collisions. Each master gets a req/ack handshake. The arbiter serialises accesses with round-robin fairness and returns read data to the master that issued the read.

## Interface
- ADDR_W, 3, register address width
- DATA_W, 16, register data width
- RD_LAT, 1, cycles from acc_en_o high to valid rdata_i; legal range 0..3
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m0_req_i / m1_req_i  in  1  request; held high until the matching ack
- m0_wr_i / m1_wr_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  ADDR_W  register address
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- m0_rdata_o / m1_rdata_o  out  DATA_W  last read result for that master
- acc_en_o  out  1  register-bus access strobe
- wr_en_o  out  1  register-bus write enable
- addr_o  out  ADDR_W  register-bus address
- wdata_o  out  DATA_W  register-bus write data
- rdata_i  in  DATA_W  register-bus read data
- busy_o  out  1  a transaction is in flight
- gnt_o  out  1  index of the owning master; valid while busy_o = 1

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - Samples m0_req_i and m1_req_i.
  - A single requester wins.
  - If both request, the master not served last wins.
  - Latches the winner's wr, addr and wdata into internal registers, then moves to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - acc_en_o = 1; wr_en_o = latched wr; addr_o and wdata_o = latched values.
  - Next state:
    - write → DONE;
    - read with RD_LAT = 0 → captures rdata_i, then DONE;
    - read with RD_LAT > 0 → WAIT.
- **WAIT**
  - Lasts RD_LAT cycles; rdata_i is captured on the last WAIT cycle; next state DONE.
  - Bus outputs are idle in WAIT.
- **DONE** (1 cycle)
  - The owner's ack = 1.
  - For a read, the owner's rdata_o is updated at entry to DONE, so it is valid during the ack cycle.
  - Last-served pointer ← owner; next state IDLE.
- **Master protocol**
  - A master drops req, or presents a new transaction, on the edge after it sees ack.
  - req high in any IDLE cycle is a new request.
  - Request inputs are not re-sampled outside IDLE.
  - If a master drops req early, the latched transaction still completes and still acks.
- **Bus and status outputs**
  - When acc_en_o = 0: wr_en_o, addr_o and wdata_o are 0.
  - mX_rdata_o holds its value until that master's next read completes.
  - Writes never change mX_rdata_o.
  - busy_o = 1 in ACCESS, WAIT and DONE.
- **Reset**
  - Every output is 0; FSM is in IDLE.
  - Last-served pointer = 1, so m0 wins the first tie.
  - A reset asserted mid-transaction abandons the transaction immediately: no ack, rdata unchanged from reset value.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Write: req sampled high in IDLE at cycle T → acc_en_o high in T+1 → ack in T+2.
- Read: acc_en_o high in T+1 → ack and rdata valid in T+2+RD_LAT.
- Back-to-back: one IDLE cycle between DONE and the next ACCESS.
  - Write throughput: 3 cycles per access.
  - Read throughput: 3+RD_LAT cycles per access.
- Both masters requesting continuously: grants strictly alternate m0, m1, m0, …
- A master requesting alone may be granted repeatedly.

## Test plan
- Single write: m0 writes addr 3, data 0x1234 → acc_en_o = wr_en_o = 1, addr_o = 3, wdata_o = 0x1234 for exactly 1 cycle; m0_ack_o pulses 2 cycles after req sampled; m1_ack_o stays 0.
- Read latency, run with RD_LAT = 0, 1 and 3:
  - Model returns 0x00AB for addr 5.
  - m1 reads addr 5 → m1_ack_o at T+2+RD_LAT with m1_rdata_o = 0x00AB.
  - m0_rdata_o stays 0.
- Tie after reset: both masters request in the same IDLE cycle → m0 is served first, then m1; with both held, the next 4 grants are m0, m1, m0, m1.
- Starvation check: m1 requests back-to-back continuously, m0 raises req once → m0 is granted within one m1 transaction (≤ 3+RD_LAT cycles of delay).
- Reset mid-read: assert rst_i during WAIT → all outputs 0 asynchronously, no ack; after release, a fresh m0 read completes normally.
- Early drop: m0 deasserts req during ACCESS of its write → write still reaches the bus and m0_ack_o still pulses once.
